// File: rtl/ft_nmr_write_voter.sv
// ft_nmr_write_voter: N-channel (2 or 3) redundant write voter.
// Compares the {we, addr, data} tuples from NUM_CH replicated cores each cycle
// and commits the agreed (or majority) write to one shared memory port. It
// flags minority channels and stalls fetch for a retry on unresolvable
// disagreement. It latches FATAL after RETRY_MAX consecutive unresolved votes.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   we_i           per-channel write enable
//   addr_i         per-channel address, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   data_i         per-channel data,    channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   mem_we_o       single-cycle memory write strobe
//   mem_addr_o     memory write address (holds when mem_we_o=0)
//   mem_data_o     memory write data    (holds when mem_we_o=0)
//   fetch_block_o  stall request to all cores
//   fault_ch_o     sticky per-channel fault flags
//   err_cnt_o      saturating mismatch counter
//   fatal_o        unrecoverable-fault indication
module ft_nmr_write_voter #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned STALL_CYCLES = 4,
  parameter int unsigned RETRY_MAX    = 3,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0]              we_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   data_i,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_data_o,
  output logic                           fetch_block_o,
  output logic [NUM_CH-1:0]              fault_ch_o,
  output logic [CNT_WIDTH-1:0]           err_cnt_o,
  output logic                           fatal_o
);

  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FATAL = 2'd2
  } state_t;

  state_t                  state;
  logic [STALL_W-1:0]      stall_cnt;
  logic [RETRY_W-1:0]      retry_cnt;
  logic [RETRY_W-1:0]      retry_next_c;

  // Per-channel views of the flattened input buses
  logic [ADDR_WIDTH-1:0]   ch_addr [NUM_CH];
  logic [DATA_WIDTH-1:0]   ch_data [NUM_CH];

  // Vote results
  logic                    vote_unan_c;
  logic                    vote_maj_c;
  logic [NUM_CH-1:0]       minority_c;
  logic                    sel_we_c;
  logic [ADDR_WIDTH-1:0]   sel_addr_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_split
    assign ch_addr[k] = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign ch_data[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Tuples are equal when the enables match; addr/data only matter for writes
  function automatic logic tuple_eq(
    input logic                  wa,
    input logic [ADDR_WIDTH-1:0] aa,
    input logic [DATA_WIDTH-1:0] da,
    input logic                  wb,
    input logic [ADDR_WIDTH-1:0] ab,
    input logic [DATA_WIDTH-1:0] db
  );
    return (wa == wb) && (!wa || ((aa == ab) && (da == db)));
  endfunction

  if (NUM_CH == 3) begin : g_tri
    logic eq01, eq02, eq12;
    assign eq01 = tuple_eq(we_i[0], ch_addr[0], ch_data[0], we_i[1], ch_addr[1], ch_data[1]);
    assign eq02 = tuple_eq(we_i[0], ch_addr[0], ch_data[0], we_i[2], ch_addr[2], ch_data[2]);
    assign eq12 = tuple_eq(we_i[1], ch_addr[1], ch_data[1], we_i[2], ch_addr[2], ch_data[2]);

    // Equality is transitive, so at most one pair can match without unanimity
    always_comb begin
      vote_unan_c = eq01 && eq12;
      vote_maj_c  = 1'b0;
      minority_c  = '0;
      sel_we_c    = we_i[0];
      sel_addr_c  = ch_addr[0];
      sel_data_c  = ch_data[0];
      if (!vote_unan_c) begin
        if (eq01) begin
          vote_maj_c = 1'b1;
          minority_c = NUM_CH'(3'b100);
        end else if (eq02) begin
          vote_maj_c = 1'b1;
          minority_c = NUM_CH'(3'b010);
        end else if (eq12) begin
          vote_maj_c = 1'b1;
          minority_c = NUM_CH'(3'b001);
          sel_we_c   = we_i[1];
          sel_addr_c = ch_addr[1];
          sel_data_c = ch_data[1];
        end
      end
    end
  end else if (NUM_CH == 2) begin : g_dual
    // Two channels can only agree or fail to resolve
    assign vote_unan_c = tuple_eq(we_i[0], ch_addr[0], ch_data[0], we_i[1], ch_addr[1], ch_data[1]);
    assign vote_maj_c  = 1'b0;
    assign minority_c  = '0;
    assign sel_we_c    = we_i[0];
    assign sel_addr_c  = ch_addr[0];
    assign sel_data_c  = ch_data[0];
  end else begin : g_bad_num_ch
    $error("ft_nmr_write_voter: NUM_CH must be 2 or 3");
    assign vote_unan_c = 1'b0;
    assign vote_maj_c  = 1'b0;
    assign minority_c  = '0;
    assign sel_we_c    = 1'b0;
    assign sel_addr_c  = '0;
    assign sel_data_c  = '0;
  end

  assign retry_next_c = retry_cnt + RETRY_W'(1);

  // Voter FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_RUN;
      stall_cnt     <= '0;
      retry_cnt     <= '0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
      fetch_block_o <= 1'b0;
      fault_ch_o    <= '0;
      err_cnt_o     <= '0;
      fatal_o       <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      case (state)
        ST_RUN: begin
          if (vote_unan_c || vote_maj_c) begin
            retry_cnt <= '0;
            if (sel_we_c) begin
              mem_we_o   <= 1'b1;
              mem_addr_o <= sel_addr_c;
              mem_data_o <= sel_data_c;
            end
            if (vote_maj_c) begin
              fault_ch_o <= fault_ch_o | minority_c;
              if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
            end
          end else begin
            retry_cnt     <= retry_next_c;
            fetch_block_o <= 1'b1;
            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
            if (retry_next_c == RETRY_W'(RETRY_MAX)) begin
              state   <= ST_FATAL;
              fatal_o <= 1'b1;
            end else begin
              state     <= ST_STALL;
              stall_cnt <= STALL_W'(STALL_CYCLES);
            end
          end
        end
        ST_STALL: begin
          // The load cycle counts as the first stall cycle
          if (stall_cnt <= STALL_W'(1)) begin
            state         <= ST_RUN;
            stall_cnt     <= '0;
            fetch_block_o <= 1'b0;
          end else begin
            stall_cnt <= stall_cnt - STALL_W'(1);
          end
        end
        ST_FATAL: begin
          fetch_block_o <= 1'b1;
          fatal_o       <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_nmr_write_voter.sv
// Self-checking bench for ft_nmr_write_voter: a 3-channel and a 2-channel
// instance share one stimulus stream (the dual instance sees channels 0/1).
module tb_ft_nmr_write_voter;

  localparam int STALL = 4;
  localparam int RMAX  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  we;
  logic [14:0] addr;
  logic [95:0] data;

  logic        m3_we, fb3, fatal3;
  logic [4:0]  m3_addr;
  logic [31:0] m3_data;
  logic [2:0]  fault3;
  logic [7:0]  err3;

  logic        m2_we, fb2, fatal2;
  logic [4:0]  m2_addr;
  logic [31:0] m2_data;
  logic [1:0]  fault2;
  logic [7:0]  err2;

  ft_nmr_write_voter #(.NUM_CH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .addr_i(addr), .data_i(data),
    .mem_we_o(m3_we), .mem_addr_o(m3_addr), .mem_data_o(m3_data),
    .fetch_block_o(fb3), .fault_ch_o(fault3), .err_cnt_o(err3), .fatal_o(fatal3)
  );

  ft_nmr_write_voter #(.NUM_CH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .we_i(we[1:0]), .addr_i(addr[9:0]), .data_i(data[63:0]),
    .mem_we_o(m2_we), .mem_addr_o(m2_addr), .mem_data_o(m2_data),
    .fetch_block_o(fb2), .fault_ch_o(fault2), .err_cnt_o(err2), .fatal_o(fatal2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what the voter should present after each edge
  typedef struct {
    logic        mem_we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        fb;
    logic [2:0]  fault;
    logic [7:0]  err;
    logic        fatal;
    int          stall_left;
    int          retries;
  } model_t;

  model_t m3, m2;

  function automatic model_t model_next(input model_t m, input int nch, input logic r,
                                        input logic [2:0] w, input logic [14:0] a,
                                        input logic [95:0] d);
    model_t n = m;
    logic [37:0] key [3];
    int agree [3];
    int best, bestk;
    n.mem_we = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (m.fatal) return n;
    if (m.stall_left > 0) begin
      n.stall_left = m.stall_left - 1;
      n.fb = (n.stall_left > 0);
      return n;
    end
    for (int k = 0; k < nch; k++)
      key[k] = w[k] ? {1'b1, a[k*5 +: 5], d[k*32 +: 32]} : 38'd0;
    best = 0;
    bestk = 0;
    for (int k = 0; k < nch; k++) begin
      agree[k] = 0;
      for (int j = 0; j < nch; j++)
        if (key[j] == key[k]) agree[k]++;
      if (agree[k] > best) begin
        best = agree[k];
        bestk = k;
      end
    end
    if (best == nch || (nch == 3 && best == 2)) begin
      n.retries = 0;
      if (w[bestk]) begin
        n.mem_we = 1'b1;
        n.addr = a[bestk*5 +: 5];
        n.data = d[bestk*32 +: 32];
      end
      if (best != nch) begin
        for (int k = 0; k < nch; k++)
          if (agree[k] == 1) n.fault[k] = 1'b1;
        if (n.err != 8'hFF) n.err = n.err + 8'd1;
      end
    end else begin
      if (n.err != 8'hFF) n.err = n.err + 8'd1;
      n.retries = m.retries + 1;
      n.fb = 1'b1;
      if (n.retries == RMAX) n.fatal = 1'b1;
      else n.stall_left = STALL;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    m3 = model_next(m3, 3, rst, we, addr, data);
    m2 = model_next(m2, 2, rst, we, addr, data);
    #1;
    chk("m3_we", m3_we, m3.mem_we);
    chk("m3_addr", m3_addr, m3.addr);
    chk("m3_data", m3_data, m3.data);
    chk("m3_fb", fb3, m3.fb);
    chk("m3_fault", fault3, m3.fault);
    chk("m3_err", err3, m3.err);
    chk("m3_fatal", fatal3, m3.fatal);
    chk("m2_we", m2_we, m2.mem_we);
    chk("m2_addr", m2_addr, m2.addr);
    chk("m2_data", m2_data, m2.data);
    chk("m2_fb", fb2, m2.fb);
    chk("m2_fault", fault2, m2.fault[1:0]);
    chk("m2_err", err2, m2.err);
    chk("m2_fatal", fatal2, m2.fatal);
  endtask

  task automatic drive(input logic r, input logic [2:0] w, input logic [14:0] a, input logic [95:0] d);
    rst = r;
    we = w;
    addr = a;
    data = d;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  we;
    logic [14:0] addr;
    logic [95:0] data;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_fb;
    logic [2:0]  e_fault;
    logic [7:0]  e_err;
    logic        e_fatal;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n_fb, n_cyc, saw_we;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        bw;

    m3 = '{default: 0};
    m2 = '{default: 0};
    drive(1'b1, 3'b000, 15'd0, 96'd0);

    // Hand-derived expectations for the 3-channel instance
    tbl[0] = '{1'b1, 3'b000, 15'd0, 96'd0,
               1'b0, 5'd0, 32'd0, 1'b0, 3'b000, 8'd0, 1'b0};
    tbl[1] = '{1'b0, 3'b111, {5'd10, 5'd10, 5'd10}, {32'd100, 32'd100, 32'd100},
               1'b1, 5'd10, 32'd100, 1'b0, 3'b000, 8'd0, 1'b0};
    tbl[2] = '{1'b0, 3'b000, 15'd0, 96'd0,
               1'b0, 5'd10, 32'd100, 1'b0, 3'b000, 8'd0, 1'b0};
    tbl[3] = '{1'b0, 3'b111, {5'd10, 5'd10, 5'd10}, {32'd100, 32'd99, 32'd100},
               1'b1, 5'd10, 32'd100, 1'b0, 3'b010, 8'd1, 1'b0};
    tbl[4] = '{1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'd7},
               1'b0, 5'd10, 32'd100, 1'b0, 3'b011, 8'd2, 1'b0};
    tbl[5] = '{1'b0, 3'b111, {5'd4, 5'd3, 5'd3}, {32'd33, 32'd33, 32'd33},
               1'b1, 5'd3, 32'd33, 1'b0, 3'b111, 8'd3, 1'b0};
    tbl[6] = '{1'b1, 3'b111, {5'd1, 5'd1, 5'd1}, {32'd1, 32'd1, 32'd1},
               1'b0, 5'd0, 32'd0, 1'b0, 3'b000, 8'd0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].addr, tbl[i].data);
      step();
      chk($sformatf("tbl%0d_we", i), m3_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_addr", i), m3_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_data", i), m3_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_fb", i), fb3, tbl[i].e_fb);
      chk($sformatf("tbl%0d_fault", i), fault3, tbl[i].e_fault);
      chk($sformatf("tbl%0d_err", i), err3, tbl[i].e_err);
      chk($sformatf("tbl%0d_fatal", i), fatal3, tbl[i].e_fatal);
    end

    // Address sweep: one commit per cycle, in order, no stall
    for (int i = 0; i < 32; i++) begin
      ba = 5'(i);
      bd = 32'(i * 10);
      drive(1'b0, 3'b111, {ba, ba, ba}, {bd, bd, bd});
      step();
      chk("sweep_we", m3_we, 1'b1);
      chk("sweep_addr", m3_addr, ba);
      chk("sweep_data", m3_data, bd);
      chk("sweep_fb", fb3, 1'b0);
    end

    // Dual channel: enable mismatch stalls for exactly STALL cycles
    drive(1'b1, 3'b000, 15'd0, 96'd0);
    step();
    drive(1'b0, 3'b001, {5'd0, 5'd0, 5'd10}, {32'd0, 32'd0, 32'd100});
    step();
    n_fb = fb2 ? 1 : 0;
    saw_we = m2_we ? 1 : 0;
    drive(1'b0, 3'b000, 15'd0, 96'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (fb2) n_fb++;
      if (m2_we) saw_we++;
    end
    chk("dual_stall_len", 32'(n_fb), 32'd4);
    chk("dual_err", err2, 8'd1);
    chk("dual_no_commit", 32'(saw_we), 32'd0);
    chk("tri_idle_major_fault0", fault3[0], 1'b1);

    // Three unresolved votes in a row reach FATAL
    drive(1'b1, 3'b000, 15'd0, 96'd0);
    step();
    drive(1'b0, 3'b111, {5'd1, 5'd1, 5'd1}, {32'd3, 32'd2, 32'd1});
    n_cyc = 0;
    for (int i = 1; i <= 30 && n_cyc == 0; i++) begin
      step();
      if (fatal3) n_cyc = i;
    end
    chk("fatal_latency", 32'(n_cyc), 32'd11);
    chk("fatal_err", err3, 8'd3);
    drive(1'b0, 3'b111, {5'd7, 5'd7, 5'd7}, {32'd9, 32'd9, 32'd9});
    for (int i = 0; i < 50; i++) begin
      step();
      chk("fatal_hold", fatal3, 1'b1);
      chk("fatal_fb", fb3, 1'b1);
      chk("fatal_no_we", m3_we, 1'b0);
    end
    drive(1'b1, 3'b111, {5'd7, 5'd7, 5'd7}, {32'd9, 32'd9, 32'd9});
    step();
    chk("fatal_cleared", fatal3, 1'b0);
    chk("fatal_fb_cleared", fb3, 1'b0);
    chk("fatal_err_cleared", err3, 8'd0);

    // Randomised traffic with occasional corruption and resets
    for (int i = 0; i < 2000; i++) begin
      bw = ($urandom_range(0, 3) != 0);
      ba = 5'($urandom_range(0, 31));
      bd = 32'($urandom_range(0, 7));
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 3; k++) begin
        we[k] = bw;
        addr[k*5 +: 5] = ba;
        data[k*32 +: 32] = bd;
        case ($urandom_range(0, 11))
          0: we[k] = ~bw;
          1: addr[k*5 +: 5] = 5'($urandom_range(0, 31));
          2: data[k*32 +: 32] = 32'($urandom_range(0, 7));
          default: ;
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
